// File: rtl/alu_issue_stage_if.sv
// Bundle between decode/register-read and the ALU issue slot: the upstream beat,
// the downstream issued beat and both handshakes. o_illegal exists only with ALU_ISSUE_TRAP_EN.
interface alu_issue_stage_if #(
  parameter int XLEN = 32
);
  logic            i_flush;
  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_instr;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_rs1_data;
  logic [XLEN-1:0] i_rs2_data;
  logic [XLEN-1:0] i_imm;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_a;
  logic [XLEN-1:0] o_b;
  logic [3:0]      o_alucontrol;
  logic [4:0]      o_rd;
  logic            o_regwrite;
  logic            o_is_branch;
  logic [XLEN-1:0] o_rs2_store;
`ifdef ALU_ISSUE_TRAP_EN
  logic            o_illegal;
`endif

  // The issue stage itself.
  modport slave (
    input  i_flush, i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_imm, i_ready,
    output o_ready, o_valid, o_a, o_b, o_alucontrol, o_rd, o_regwrite, o_is_branch,
`ifdef ALU_ISSUE_TRAP_EN
    output o_illegal,
`endif
    output o_rs2_store
  );

  // Whoever drives the stage: decode upstream and execute downstream.
  modport master (
    output i_flush, i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_imm, i_ready,
    input  o_ready, o_valid, o_a, o_b, o_alucontrol, o_rd, o_regwrite, o_is_branch,
`ifdef ALU_ISSUE_TRAP_EN
    input  o_illegal,
`endif
    input  o_rs2_store
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: decodes ALU op and operands into a one-entry ID->EX slot with
// valid/ready, stall and flush. Define ALU_ISSUE_TRAP_EN to register an o_illegal flag.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input logic              i_clk,
  input logic              i_rst,
  alu_issue_stage_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SLL    = 4'b0001,
    ALU_LT     = 4'b0010,
    ALU_LTU    = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SRL    = 4'b0101,
    ALU_OR     = 4'b0110,
    ALU_AND    = 4'b0111,
    ALU_SUB    = 4'b1000,
    ALU_SRA    = 4'b1001,
    ALU_BPS2   = 4'b1010,
    ALU_EQUAL  = 4'b1011,
    ALU_NEQUAL = 4'b1100,
    ALU_GE     = 4'b1101,
    ALU_GEU    = 4'b1111
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [XLEN-1:0] LINK_OFFSET = XLEN'(4);

  // Shared funct3 map for register and immediate arithmetic; alt picks SUB/SRA.
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_LT;
      3'b011:  arith_op = ALU_LTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_field;

  assign opcode   = bus.i_instr[6:0];
  assign funct3   = bus.i_instr[14:12];
  assign funct7   = bus.i_instr[31:25];
  assign rd_field = bus.i_instr[11:7];

  alu_op_e         op_d,  op_q;
  logic [XLEN-1:0] a_d,   a_q;
  logic [XLEN-1:0] b_d,   b_q;
  logic [XLEN-1:0] st_d,  st_q;
  logic [4:0]      rd_q;
  logic            wr_d,  wr_q;
  logic            br_d,  br_q;
  logic            ill_d;
  logic            valid_d, valid_q;
  logic            accept;

  always_comb begin
    // NOTE: every decode output gets a default before the case so no path infers a latch.
    op_d  = ALU_ADD;
    a_d   = bus.i_rs1_data;
    b_d   = bus.i_imm;
    st_d  = '0;
    wr_d  = 1'b0;
    br_d  = 1'b0;
    ill_d = 1'b0;

    case (opcode)
      OP_R: begin
        b_d  = bus.i_rs2_data;
        wr_d = 1'b1;
        if (funct7 == 7'h00) begin
          op_d = arith_op(funct3, 1'b0);
        end else if (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          op_d = arith_op(funct3, 1'b1);
        end else begin
          ill_d = 1'b1;
        end
      end
      OP_IMM: begin
        wr_d = 1'b1;
        op_d = arith_op(funct3, (funct3 == 3'b101) && funct7[5]);
        if (funct3 == 3'b001 && funct7 != 7'h00) ill_d = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20) ill_d = 1'b1;
      end
      OP_LOAD:  wr_d = 1'b1;
      OP_STORE: st_d = bus.i_rs2_data;
      OP_LUI: begin
        op_d = ALU_BPS2;
        wr_d = 1'b1;
      end
      OP_AUIPC: begin
        a_d  = bus.i_pc;
        wr_d = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        a_d  = bus.i_pc;
        b_d  = LINK_OFFSET;
        wr_d = 1'b1;
      end
      OP_BRANCH: begin
        b_d  = bus.i_rs2_data;
        br_d = 1'b1;
        case (funct3)
          3'b000:  op_d = ALU_EQUAL;
          3'b001:  op_d = ALU_NEQUAL;
          3'b100:  op_d = ALU_LT;
          3'b101:  op_d = ALU_GE;
          3'b110:  op_d = ALU_LTU;
          3'b111:  op_d = ALU_GEU;
          default: ill_d = 1'b1;
        endcase
      end
      default: ill_d = 1'b1;
    endcase

    // Illegal beats still issue, but as a harmless non-writing ADD.
    if (ill_d) begin
      op_d = ALU_ADD;
      wr_d = 1'b0;
      br_d = 1'b0;
    end
    if (rd_field == 5'd0) wr_d = 1'b0;
  end

  assign bus.o_ready = ~valid_q | bus.i_ready;
  assign accept      = bus.i_valid & bus.o_ready & ~bus.i_flush;

  always_comb begin
    valid_d = valid_q;
    if (bus.i_flush)       valid_d = 1'b0;
    else if (accept)       valid_d = 1'b1;
    else if (bus.i_ready)  valid_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  // Payload loads only on accept, which holds it stable through a stall; flush leaves it stale.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q  <= ALU_ADD;
      a_q   <= '0;
      b_q   <= '0;
      st_q  <= '0;
      rd_q  <= '0;
      wr_q  <= 1'b0;
      br_q  <= 1'b0;
    end else if (accept) begin
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      st_q  <= st_d;
      rd_q  <= rd_field;
      wr_q  <= wr_d;
      br_q  <= br_d;
    end
  end

`ifdef ALU_ISSUE_TRAP_EN
  logic ill_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)       ill_q <= 1'b0;
    else if (accept) ill_q <= ill_d;
  end

  assign bus.o_illegal = ill_q;
`endif

  assign bus.o_valid      = valid_q;
  assign bus.o_a          = a_q;
  assign bus.o_b          = b_q;
  assign bus.o_alucontrol = op_q;
  assign bus.o_rd         = rd_q;
  assign bus.o_regwrite   = wr_q;
  assign bus.o_is_branch  = br_q;
  assign bus.o_rs2_store  = st_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: reset, decode of each instruction class, stall,
// flush, reset mid-stall and illegal encodings (o_illegal checked when ALU_ISSUE_TRAP_EN).
module tb_alu_issue_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  alu_issue_stage_if #(.XLEN(XLEN)) bus ();

  alu_issue_stage #(.XLEN(XLEN)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle so outputs are sampled away from the clock edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [XLEN-1:0] pc,
                       input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                       input logic [XLEN-1:0] imm);
    bus.i_valid    = 1'b1;
    bus.i_instr    = instr;
    bus.i_pc       = pc;
    bus.i_rs1_data = rs1;
    bus.i_rs2_data = rs2;
    bus.i_imm      = imm;
  endtask

  initial begin
    rst            = 1'b1;
    bus.i_flush    = 1'b0;
    bus.i_valid    = 1'b0;
    bus.i_ready    = 1'b0;
    bus.i_instr    = '0;
    bus.i_pc       = '0;
    bus.i_rs1_data = '0;
    bus.i_rs2_data = '0;
    bus.i_imm      = '0;

    tick();
    tick();
    check("rst_valid", bus.o_valid, 0);
    check("rst_aluctl", bus.o_alucontrol, 0);
    check("rst_ready", bus.o_ready, 1);
    check("rst_a", bus.o_a, 0);
    check("rst_regwrite", bus.o_regwrite, 0);
    rst = 1'b0;

    // sub x2,x1,x2
    bus.i_ready = 1'b1;
    offer(32'h4020_8133, 32'h0000_0040, 32'd10, 32'd3, 32'd0);
    tick();
    check("sub_valid", bus.o_valid, 1);
    check("sub_aluctl", bus.o_alucontrol, 4'b1000);
    check("sub_a", bus.o_a, 10);
    check("sub_b", bus.o_b, 3);
    check("sub_rd", bus.o_rd, 2);
    check("sub_regwrite", bus.o_regwrite, 1);
    check("sub_branch", bus.o_is_branch, 0);

    // Stall three cycles with add x3,x1,x2 waiting upstream.
    bus.i_ready = 1'b0;
    offer(32'h0020_81B3, 32'h0000_0044, 32'd7, 32'd8, 32'd0);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_ready", bus.o_ready, 0);
      tick();
      check("stall_valid", bus.o_valid, 1);
      check("stall_aluctl", bus.o_alucontrol, 4'b1000);
      check("stall_a", bus.o_a, 10);
      check("stall_rd", bus.o_rd, 2);
    end
    bus.i_ready = 1'b1;
    #1;
    check("release_ready", bus.o_ready, 1);
    tick();
    check("nobubble_valid", bus.o_valid, 1);
    check("add_aluctl", bus.o_alucontrol, 4'b0000);
    check("add_a", bus.o_a, 7);
    check("add_b", bus.o_b, 8);
    check("add_rd", bus.o_rd, 3);

    // Consume without a new beat drains the slot.
    bus.i_valid = 1'b0;
    tick();
    check("drain_valid", bus.o_valid, 0);

    // bge x1,x2 with rs1=-1, rs2=0
    offer(32'h0020_D063, 32'h0000_0080, 32'hFFFF_FFFF, 32'd0, 32'd0);
    tick();
    check("bge_aluctl", bus.o_alucontrol, 4'b1101);
    check("bge_branch", bus.o_is_branch, 1);
    check("bge_regwrite", bus.o_regwrite, 0);
    check("bge_a", bus.o_a, 32'hFFFF_FFFF);
    check("bge_b", bus.o_b, 0);

    // srai x6,x1,3: B is the immediate, SRA selected by funct7[5].
    offer(32'h4030_D313, 32'h0000_0084, 32'h8000_0000, 32'd9, 32'h0000_0403);
    tick();
    check("srai_aluctl", bus.o_alucontrol, 4'b1001);
    check("srai_b", bus.o_b, 32'h0000_0403);
    check("srai_rd", bus.o_rd, 6);

    // sw x2,0(x1)
    offer(32'h0020_A023, 32'h0000_0088, 32'h0000_1000, 32'hCAFE_F00D, 32'd16);
    tick();
    check("sw_aluctl", bus.o_alucontrol, 4'b0000);
    check("sw_b", bus.o_b, 16);
    check("sw_regwrite", bus.o_regwrite, 0);
    check("sw_rs2_store", bus.o_rs2_store, 32'hCAFE_F00D);

    // lui x7,0x12345
    offer(32'h1234_53B7, 32'h0000_008C, 32'd1, 32'd2, 32'h1234_5000);
    tick();
    check("lui_aluctl", bus.o_alucontrol, 4'b1010);
    check("lui_b", bus.o_b, 32'h1234_5000);
    check("lui_regwrite", bus.o_regwrite, 1);

    // jal x1: link value pc+4
    offer(32'h0000_00EF, 32'h0000_0100, 32'd5, 32'd6, 32'h0000_0020);
    tick();
    check("jal_a", bus.o_a, 32'h0000_0100);
    check("jal_b", bus.o_b, 4);
    check("jal_aluctl", bus.o_alucontrol, 4'b0000);
    check("jal_rd", bus.o_rd, 1);

    // addi x0,x0,0 must not write
    offer(32'h0000_0013, 32'h0000_0104, 32'd0, 32'd0, 32'd0);
    tick();
    check("nop_regwrite", bus.o_regwrite, 0);

    // Flush with a held beat and a new offer: both disappear.
    bus.i_ready = 1'b0;
    bus.i_flush = 1'b1;
    offer(32'h1234_53B7, 32'h0000_0108, 32'd1, 32'd2, 32'h5555_5000);
    tick();
    check("flush_valid", bus.o_valid, 0);
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    tick();
    check("flush_dropped", bus.o_valid, 0);

    // Illegal opcode 0x7F with rd=2.
    bus.i_ready = 1'b1;
    offer(32'h0000_017F, 32'h0000_0200, 32'd1, 32'd2, 32'd3);
    tick();
    check("ill_op_valid", bus.o_valid, 1);
    check("ill_op_aluctl", bus.o_alucontrol, 4'b0000);
    check("ill_op_regwrite", bus.o_regwrite, 0);
    check("ill_op_branch", bus.o_is_branch, 0);
`ifdef ALU_ISSUE_TRAP_EN
    check("ill_op_flag", bus.o_illegal, 1);
`endif

    // R-type funct7 0x20 with funct3 001 is illegal.
    offer(32'h4020_9133, 32'h0000_0204, 32'd1, 32'd2, 32'd0);
    tick();
    check("ill_r_aluctl", bus.o_alucontrol, 4'b0000);
    check("ill_r_regwrite", bus.o_regwrite, 0);
`ifdef ALU_ISSUE_TRAP_EN
    check("ill_r_flag", bus.o_illegal, 1);
`endif

    // Branch funct3 010 is illegal: no branch flag.
    offer(32'h0020_A063, 32'h0000_0208, 32'd1, 32'd2, 32'd0);
    tick();
    check("ill_br_branch", bus.o_is_branch, 0);
    check("ill_br_aluctl", bus.o_alucontrol, 4'b0000);

    // Legal beat clears the flag.
    offer(32'h0020_81B3, 32'h0000_020C, 32'd4, 32'd4, 32'd0);
    tick();
    check("legal_regwrite", bus.o_regwrite, 1);
`ifdef ALU_ISSUE_TRAP_EN
    check("legal_flag", bus.o_illegal, 0);
`endif

    // Reset during a stall returns everything to reset values.
    bus.i_ready = 1'b0;
    offer(32'h0000_00EF, 32'h0000_0300, 32'd1, 32'd2, 32'd3);
    tick();
    rst = 1'b1;
    tick();
    check("rststall_valid", bus.o_valid, 0);
    check("rststall_a", bus.o_a, 0);
    check("rststall_b", bus.o_b, 0);
    check("rststall_rd", bus.o_rd, 0);
    check("rststall_regwrite", bus.o_regwrite, 0);
    check("rststall_ready", bus.o_ready, 1);
    rst = 1'b0;
    bus.i_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
